// File: rtl/demux_reg_bank.sv
// demux_reg_bank: register bank fed through a one-entry pending stage.
// A write request is captured into the pending stage on accept and written
// into the addressed register on the following unstalled edge (commit).
//
// Handshake: a request transfers on a rising edge where wr_valid and
// wr_ready are both 1. wr_ready is combinational (!pending || !hold), so a
// full stage that is committing this edge can take a new request on that
// same edge. wr_valid may be raised or dropped freely; the request fields
// are only sampled on a transfer edge.
module demux_reg_bank #(
  parameter int N       = 32,
  parameter int Bits    = 32,
  parameter int ZeroReg = 1,
  localparam int CW     = $clog2(N)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_valid,
  output logic                     wr_ready,
  input  logic [CW-1:0]            wr_code,
  input  logic [Bits-1:0]          wr_data,
  input  logic                     hold,
  output logic [N-1:0][Bits-1:0]   Q,
  output logic                     wr_done,
  output logic [CW-1:0]            wr_done_code,
  output logic [15:0]              wr_count,
  output logic                     err
);

  // Pending stage
  logic            pend_q, pend_d;
  logic [CW-1:0]   pend_code_q, pend_code_d;
  logic [Bits-1:0] pend_data_q, pend_data_d;

  // Register bank
  logic [N-1:0][Bits-1:0] bank_q, bank_d;

  // Commit status
  logic          done_q, done_d;
  logic [CW-1:0] done_code_q, done_code_d;
  logic [15:0]   count_q, count_d;
  logic          err_q, err_d;

  logic accept;
  logic commit;
  logic in_range;
  logic commit_ok;

  assign wr_ready  = !pend_q || !hold;
  assign accept    = wr_valid && wr_ready;
  assign commit    = pend_q && !hold;
  // Only meaningful when N is not a power of two; otherwise always true.
  assign in_range  = (32'(pend_code_q) < 32'(N));
  assign commit_ok = commit && in_range;

  // Next state of the pending stage: a new accept replaces the committing entry.
  always_comb begin
    pend_d      = pend_q;
    pend_code_d = pend_code_q;
    pend_data_d = pend_data_q;
    if (accept) begin
      pend_d      = 1'b1;
      pend_code_d = wr_code;
      pend_data_d = wr_data;
    end else if (commit) begin
      pend_d      = 1'b0;
    end
  end

  // Next state of the bank: only the addressed register changes; register 0
  // stays zero when ZeroReg is set.
  always_comb begin
    bank_d = bank_q;
    for (int i = 0; i < N; i++) begin
      if (commit_ok && (pend_code_q == CW'(i)) && !((ZeroReg != 0) && (i == 0))) begin
        bank_d[i] = pend_data_q;
      end
    end
  end

  // Next state of the commit status outputs.
  always_comb begin
    done_d      = commit_ok;
    done_code_d = done_code_q;
    count_d     = count_q;
    err_d       = err_q;
    if (commit_ok) begin
      done_code_d = pend_code_q;
      count_d     = count_q + 16'd1;
    end
    if (commit && !in_range) begin
      err_d = 1'b1;
    end
  end

  // Pending stage registers; reset discards any pending entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_q      <= 1'b0;
      pend_code_q <= '0;
      pend_data_q <= '0;
    end else begin
      pend_q      <= pend_d;
      pend_code_q <= pend_code_d;
      pend_data_q <= pend_data_d;
    end
  end

  // Register bank storage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bank_q <= '0;
    end else begin
      bank_q <= bank_d;
    end
  end

  // Commit status registers (done pulse, index, counter, sticky error).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done_q      <= 1'b0;
      done_code_q <= '0;
      count_q     <= '0;
      err_q       <= 1'b0;
    end else begin
      done_q      <= done_d;
      done_code_q <= done_code_d;
      count_q     <= count_d;
      err_q       <= err_d;
    end
  end

  assign Q            = bank_q;
  assign wr_done      = done_q;
  assign wr_done_code = done_code_q;
  assign wr_count     = count_q;
  assign err          = err_q;

endmodule

// File: doc/demux_reg_bank.md
DEMUX_REG_BANK -- requirements
Module: demux_reg_bank

Interface
REQ-001 Parameter N, default 32: number of registers in the bank; legal values are N >= 2.
REQ-002 Parameter Bits, default 32: width of each register.
REQ-003 Parameter ZeroReg, default 1: when set to 1, register 0 is hardwired to zero.
REQ-004 Port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 Port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-006 Port wr_valid, input, 1 bit: a write request is presented.
REQ-007 Port wr_ready, output, 1 bit: the block can accept a request this cycle.
REQ-008 Port wr_code, input, $clog2(N) bits: target register index.
REQ-009 Port wr_data, input, Bits bits: write data.
REQ-010 Port hold, input, 1 bit: stalls the commit stage.
REQ-011 Port Q, output, array [N-1:0] of [Bits-1:0]: current contents of every register, for downstream read muxing.
REQ-012 Port wr_done, output, 1 bit: one-cycle pulse marking a completed commit.
REQ-013 Port wr_done_code, output, $clog2(N) bits: index of the completed commit.
REQ-014 Port wr_count, output, 16 bits: number of completed commits.
REQ-015 Port err, output, 1 bit: sticky flag for an out-of-range code.

Function
REQ-016 A request SHALL be accepted on a rising edge when wr_valid and wr_ready are both 1; the accepted wr_code and wr_data are captured into a one-entry pending stage and the pending flag is set.
REQ-017 wr_ready SHALL be combinational and equal to (!pending || !hold).
REQ-018 A commit SHALL occur on a rising edge when pending is 1 and hold is 0: the pending data is written to Q[pending code], and the pending flag is cleared unless a new request is accepted on the same edge.
REQ-019 Accept and commit SHALL be able to occur on the same edge, sustaining one write per cycle; the newly accepted entry replaces the committing entry in the pending stage.
REQ-020 Write latency SHALL be exactly one edge from accept to commit when hold is 0; Q reflects the new value in the cycle after the commit edge.
REQ-021 While hold is 1 and pending is 1, the pending entry SHALL remain unchanged and no new request is accepted.
REQ-022 Only the addressed register SHALL change on a commit; all other Q[i] hold their value.
REQ-023 With ZeroReg = 1, a commit to index 0 SHALL leave Q[0] at 0 but still count as a completed commit (wr_done, wr_done_code, wr_count all update).
REQ-024 With N not a power of 2, a commit whose code is >= N SHALL write no register, SHALL set err to 1 until reset, and SHALL NOT assert wr_done or increment wr_count.
REQ-025 wr_done SHALL be 1 for exactly the one cycle following each completed commit edge, with wr_done_code holding the committed index during that cycle.
REQ-026 wr_count SHALL increment by 1 on each completed commit and wrap from 0xFFFF to 0x0000.
REQ-027 Changes to wr_valid, wr_code or wr_data while the pending stage is full and hold is 1 SHALL have no effect on the bank.

Reset
REQ-028 When rst_n = 0, the block SHALL immediately and asynchronously set all Q[i] to 0, pending to 0, wr_done to 0, wr_done_code to 0, wr_count to 0 and err to 0.
REQ-029 A pending entry present when reset asserts SHALL be discarded and never committed.
REQ-030 wr_ready SHALL read 1 during reset and after reset, provided hold is 0 or no entry is pending.

Verification
REQ-031 With N=32, Bits=32: write code 5, data 0xDEADBEEF, hold 0 -> Q[5] = 0xDEADBEEF two cycles after wr_valid; wr_done pulses once with wr_done_code = 5; wr_count = 1; all other Q[i] = 0.
REQ-032 Back-to-back writes to codes 1, 2, 3 on consecutive cycles with hold 0 -> wr_ready stays 1; three consecutive wr_done pulses with codes 1, 2, 3; wr_count = 3.
REQ-033 Accept a write to code 7, raise hold for 4 cycles with wr_valid held high and a new code -> wr_ready = 0 and Q[7] is unchanged during hold; Q[7] updates on the first edge after hold falls, and the second request is then accepted.
REQ-034 With ZeroReg = 1, write 0x1234 to code 0 -> Q[0] stays 0; wr_done pulses with code 0; wr_count increments.
REQ-035 With N=24, write to code 30 -> no Q changes; err = 1 and stays 1; no wr_done pulse; wr_count unchanged.
REQ-036 Accept a write, then assert rst_n = 0 mid-cycle before the commit -> all outputs are 0 immediately, and after release the target register remains 0.
